// File: rtl/lfsr_fifo_pkg.sv
// Shared types and defaults for the LFSR-to-FIFO sequencer.
// Holds the sequencer state encoding and fabric-clock derived constants.
package lfsr_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_ACK,
        DRAIN
    } seq_state_t;

    localparam int CLK_HZ           = 50_000_000;
    localparam int DEF_DRAIN_PERIOD = CLK_HZ / 2;
    localparam int DEF_ACK_TIMEOUT  = 4;

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement, saturates at 0.
// Latency: count and zero update one cycle after load/dec.
// Backpressure: none; dec is ignored once the count reaches zero.
module interval_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lfsr_fifo_sequencer.sv
// Sequences LFSR words into the FIFO: manual gated push/pop, or auto fill-then-drain bursts.
// Latency: every strobe and status output is registered, one cycle after its cause.
// Backpressure: one push outstanding until fifo_ack; fifo_full ends a fill, fifo_empty ends a drain.
module lfsr_fifo_sequencer
    import lfsr_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int FILL_COUNT   = 16,
    parameter int DRAIN_PERIOD = DEF_DRAIN_PERIOD,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          auto_mode,
    input  logic                          start,
    input  logic                          manual_push,
    input  logic                          manual_pop,
    input  logic                          lfsr_valid,
    input  logic                          fifo_ack,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    output logic                          fifo_push,
    output logic                          fifo_pop,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(FIFO_DEPTH):0]   fill_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(DRAIN_PERIOD);
    localparam int AW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CW-1:0] FILL_TARGET = CW'(FILL_COUNT);
    localparam logic [TW-1:0] RELOAD      = TW'(DRAIN_PERIOD - 1);
    localparam logic [AW-1:0] ACK_LAST    = AW'(ACK_TIMEOUT - 1);

    if ((FILL_COUNT < 1) || (FILL_COUNT > FIFO_DEPTH)) begin : g_bad_fill_count
        $error("FILL_COUNT must lie in 1..FIFO_DEPTH");
    end
    if (DRAIN_PERIOD < 2) begin : g_bad_drain_period
        $error("DRAIN_PERIOD must be at least 2");
    end

    seq_state_t    state, state_nxt;
    logic          push_nxt, pop_nxt, done_nxt, error_nxt;
    logic [CW-1:0] fill_nxt;
    logic [AW-1:0] ack_tmr, ack_tmr_nxt;
    logic          pend, pend_nxt;
    logic          tmr_load, tmr_dec, tmr_zero;

    interval_timer #(.W(TW)) u_drain_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt   = state;
        push_nxt    = 1'b0;
        pop_nxt     = 1'b0;
        done_nxt    = 1'b0;
        error_nxt   = error;
        fill_nxt    = fill_cnt;
        ack_tmr_nxt = ack_tmr;
        pend_nxt    = pend;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        // A manual push is outstanding until acked; the timeout keeps a lost ack from locking the button out.
        if (pend) begin
            if (fifo_ack || (ack_tmr == ACK_LAST)) pend_nxt = 1'b0;
            else                                    ack_tmr_nxt = ack_tmr + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (!auto_mode) begin
                    push_nxt = manual_push && lfsr_valid && !fifo_full && !(pend && !fifo_ack);
                    pop_nxt  = manual_pop && !fifo_empty;
                    if (push_nxt) begin
                        pend_nxt    = 1'b1;
                        ack_tmr_nxt = '0;
                    end
                end else if (start) begin
                    fill_nxt  = '0;
                    error_nxt = 1'b0;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if ((fill_cnt >= FILL_TARGET) || fifo_full) begin
                    tmr_load  = 1'b1;
                    state_nxt = DRAIN;
                end else if (lfsr_valid) begin
                    push_nxt    = 1'b1;
                    ack_tmr_nxt = '0;
                    state_nxt   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (fifo_ack) begin
                    if (fill_cnt < FILL_TARGET) fill_nxt = fill_cnt + 1'b1;
                    state_nxt = FILL;
                end else if (ack_tmr == ACK_LAST) begin
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ack_tmr_nxt = ack_tmr + 1'b1;
                end
            end
            DRAIN: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!fifo_empty) begin
                    pop_nxt  = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Leaving auto mode aborts silently: no strobe, no done.
        if ((state != IDLE) && !auto_mode) begin
            state_nxt = IDLE;
            push_nxt  = 1'b0;
            pop_nxt   = 1'b0;
            done_nxt  = 1'b0;
            tmr_load  = 1'b0;
            tmr_dec   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fifo_push <= 1'b0;
            fifo_pop  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            fill_cnt  <= '0;
            ack_tmr   <= '0;
            pend      <= 1'b0;
        end else begin
            state     <= state_nxt;
            fifo_push <= push_nxt;
            fifo_pop  <= pop_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
            error     <= error_nxt;
            fill_cnt  <= fill_nxt;
            ack_tmr   <= ack_tmr_nxt;
            pend      <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_fifo_sequencer.sv
// Bench for lfsr_fifo_sequencer: FIFO environment model plus event-level expectations.
module tb_lfsr_fifo_sequencer;

    localparam int FIFO_DEPTH   = 16;
    localparam int FILL_COUNT   = 4;
    localparam int DRAIN_PERIOD = 8;
    localparam int ACK_TIMEOUT  = 4;
    localparam int CW           = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n, auto_mode, start, manual_push, manual_pop, lfsr_valid;
    logic          fifo_ack, fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop, busy, done, error;
    logic [CW-1:0] fill_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // environment controls, written only by the stimulus process
    bit ack_en, model_level, man_full, man_empty, occ_clr;
    int full_limit;
    // environment state, written only by the environment process
    int occ;
    bit push_q, pop_q;
    // manual-mode scoreboard
    int m_issued = 0;
    int m_acked  = 0;

    always #5 clk = ~clk;

    lfsr_fifo_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FILL_COUNT   (FILL_COUNT),
        .DRAIN_PERIOD (DRAIN_PERIOD),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .auto_mode   (auto_mode),
        .start       (start),
        .manual_push (manual_push),
        .manual_pop  (manual_pop),
        .lfsr_valid  (lfsr_valid),
        .fifo_ack    (fifo_ack),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_push   (fifo_push),
        .fifo_pop    (fifo_pop),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .fill_cnt    (fill_cnt)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // FIFO model: acks each push one cycle after it, counts occupancy on ack and pop.
    initial begin
        fifo_ack = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        occ = 0; push_q = 1'b0; pop_q = 1'b0;
        forever begin
            @(posedge clk); #1;
            fifo_ack = ack_en && push_q;
            if (fifo_ack) occ++;
            if (pop_q && occ > 0) occ--;
            if (occ_clr) occ = 0;
            push_q     = fifo_push;
            pop_q      = fifo_pop;
            fifo_full  = model_level ? (occ >= full_limit) : man_full;
            fifo_empty = model_level ? (occ == 0) : man_empty;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_quiet(input string tag);
        check_eq({tag, "_push"}, int'(fifo_push), 0);
        check_eq({tag, "_pop"},  int'(fifo_pop), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
    endtask

    // One manual-mode cycle: drive at negedge, predict from the rules, check at the next negedge.
    task automatic man_cycle(input bit mp, input bit mpo, input bit lv, input bit mf, input bit me, input bit st);
        bit exp_push, exp_pop, blocked;
        manual_push = mp; manual_pop = mpo; lfsr_valid = lv;
        man_full = mf; man_empty = me; start = st;
        blocked  = (m_issued > m_acked) && !fifo_ack;
        exp_push = mp && lv && !fifo_full && !blocked;
        exp_pop  = mpo && !fifo_empty;
        if (fifo_ack) m_acked++;
        if (exp_push) m_issued++;
        @(negedge clk);
        check_eq("man_push", int'(fifo_push), int'(exp_push));
        check_eq("man_pop",  int'(fifo_pop),  int'(exp_pop));
        check_eq("man_busy", int'(busy), 0);
        check_eq("man_done", int'(done), 0);
    endtask

    // One auto burst; expectations are the event timing the burst rules imply.
    task automatic auto_run(input string tag, input int full_lim, input int exp_n);
        int t, n_push, n_ack, n_pop, n_done, last_ack, first_pop, last_pop, done_t;
        n_push = 0; n_ack = 0; n_pop = 0; n_done = 0;
        last_ack = -1; first_pop = -1; last_pop = -1; done_t = -1;
        full_limit = full_lim;
        auto_mode = 1'b1; manual_push = 1'b0; manual_pop = 1'b0;
        start = 1'b1;
        lfsr_valid = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_err_clr"},  int'(error), 0);
        check_eq({tag, "_fill_clr"}, int'(fill_cnt), 0);
        t = 1;
        while (n_done == 0 && t < 3000) begin
            if (fifo_push) begin
                check_eq({tag, "_one_outstanding"}, n_push - n_ack, 0);
                n_push++;
            end
            if (fifo_ack) begin n_ack++; last_ack = t; end
            if (fifo_pop) begin
                if (n_pop > 0) check_eq({tag, "_pop_gap"}, t - last_pop, DRAIN_PERIOD);
                else           first_pop = t;
                n_pop++; last_pop = t;
            end
            if (done) begin
                n_done++; done_t = t;
                check_eq({tag, "_busy_at_done"}, int'(busy), 0);
            end else begin
                check_eq({tag, "_busy"}, int'(busy), 1);
            end
            lfsr_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_done_seen"},  n_done, 1);
        check_eq({tag, "_pushes"},     n_push, exp_n);
        check_eq({tag, "_pops"},       n_pop, exp_n);
        check_eq({tag, "_fill_cnt"},   int'(fill_cnt), exp_n);
        check_eq({tag, "_first_pop"},  first_pop, last_ack + 2 + DRAIN_PERIOD);
        check_eq({tag, "_done_time"},  done_t, last_pop + DRAIN_PERIOD);
        check_quiet({tag, "_after"});
    endtask

    initial begin
        int t, tp, te, extra, busy_te;
        reset_n = 1'b0; auto_mode = 1'b0; start = 1'b0;
        manual_push = 1'b0; manual_pop = 1'b0; lfsr_valid = 1'b0;
        ack_en = 1'b1; model_level = 1'b0; man_full = 1'b0; man_empty = 1'b1;
        occ_clr = 1'b0; full_limit = FIFO_DEPTH;
        #1;
        check_quiet("reset");
        check_eq("reset_error", int'(error), 0);
        check_eq("reset_fill",  int'(fill_cnt), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // manual: push, early second push dropped, pop on empty, push on full
        man_cycle(1, 0, 1, 0, 0, 0);
        man_cycle(1, 0, 1, 0, 0, 0);
        man_cycle(0, 0, 1, 1, 1, 0);
        man_cycle(0, 1, 1, 1, 1, 0);
        man_cycle(1, 0, 1, 1, 1, 0);
        man_cycle(1, 1, 1, 0, 0, 0);
        man_cycle(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            man_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        manual_push = 1'b0; manual_pop = 1'b0; start = 1'b0;
        model_level = 1'b1; occ_clr = 1'b1;
        repeat (3) @(negedge clk);
        occ_clr = 1'b0;

        auto_run("auto1", FIFO_DEPTH, FILL_COUNT);

        // ack withheld: error after ACK_TIMEOUT cycles, back to IDLE
        ack_en = 1'b0; lfsr_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; t = 1; tp = -1; te = -1; extra = 0; busy_te = -1;
        while (te < 0 && t < 100) begin
            if (fifo_push) begin
                if (tp < 0) tp = t; else extra++;
            end
            if (error) begin te = t; busy_te = int'(busy); end
            @(negedge clk);
            t++;
        end
        check_eq("tmo_delay", te - tp, ACK_TIMEOUT);
        check_eq("tmo_busy", busy_te, 0);
        check_eq("tmo_extra_push", extra, 0);
        repeat (3) @(negedge clk);
        check_eq("tmo_sticky", int'(error), 1);
        ack_en = 1'b1;

        auto_run("auto2", FIFO_DEPTH, FILL_COUNT);
        auto_run("autofull", 2, 2);

        // auto_mode dropped mid-drain
        full_limit = FIFO_DEPTH; start = 1'b1; lfsr_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; t = 0;
        while (!fifo_pop && t < 500) begin @(negedge clk); t++; end
        check_eq("drop_reached_pop", int'(fifo_pop), 1);
        auto_mode = 1'b0;
        @(negedge clk);
        check_eq("drop_busy", int'(busy), 0);
        extra = 0;
        for (int i = 0; i < 3 * DRAIN_PERIOD; i++) begin
            if (fifo_push || fifo_pop || done || busy) extra++;
            @(negedge clk);
        end
        check_eq("drop_quiet", extra, 0);

        // reset asserted mid-fill
        occ_clr = 1'b1; auto_mode = 1'b1;
        @(negedge clk);
        occ_clr = 1'b0; lfsr_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_fill_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_quiet("rst_async");
        check_eq("rst_async_fill", int'(fill_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1; lfsr_valid = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_push || fifo_pop || done || busy) extra++;
        end
        check_eq("rst_quiet", extra, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
